lcd_text_writer: RTL and testbench

- Consumer end of the 256-bit `characters` text bus driven by the adventure-game room logic.
- Initialises an HD44780-compatible 16x2 character LCD in 8-bit mode, then writes the 32-byte text image to the panel.
- After the first frame, it redraws the panel whenever the image changes.
- Sits between the game core and the board LCD pins; all LCD timing is generated from CLK.

---
 rtl/lcd_text_writer.sv | 177 +++++++++++++++++
 tb/tb_lcd_text_writer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_writer.sv
// HD44780 16x2 text writer: power-on wait, 8-bit init sequence, then redraws the
// 32-character image from a snapshot whenever the live image differs from it.
module lcd_text_writer #(
  parameter int unsigned POWERON_WAIT = 750000,
  parameter int unsigned E_PULSE      = 12,
  parameter int unsigned CMD_WAIT     = 2500,
  parameter int unsigned CLEAR_WAIT   = 82000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic [255:0] characters,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic         LCD_E,
  output logic [7:0]   LCD_DATA,
  output logic         busy,
  output logic         ready,
  output logic         frame_done
);

  typedef enum logic [1:0] {POWERON, INIT, FRAME, IDLE} state_t;
  typedef enum logic [1:0] {SETUP, PULSE, HOLD} phase_t;

  localparam logic [CNT_W-1:0] PON_LAST = CNT_W'(POWERON_WAIT - 1);
  localparam logic [CNT_W-1:0] EP_LAST  = CNT_W'(E_PULSE - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_WAIT - 1);

  state_t       state, n_state;
  phase_t       phase, n_phase;
  logic [CNT_W-1:0] cnt, n_cnt;
  logic [5:0]   idx, n_idx;
  logic [255:0] snap, n_snap;
  logic         rs_q, n_rs, e_q, n_e, busy_q, n_busy, ready_q, n_ready, fd_q, n_fd;
  logic [7:0]   data_q, n_data;
  logic         load_byte;
  logic [4:0]   ci;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= POWERON;
      phase   <= SETUP;
      cnt     <= '0;
      idx     <= '0;
      snap    <= '0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      e_q     <= 1'b0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state   <= n_state;
      phase   <= n_phase;
      cnt     <= n_cnt;
      idx     <= n_idx;
      snap    <= n_snap;
      rs_q    <= n_rs;
      data_q  <= n_data;
      e_q     <= n_e;
      busy_q  <= n_busy;
      ready_q <= n_ready;
      fd_q    <= n_fd;
    end
  end

  always_comb begin
    n_state   = state;
    n_phase   = phase;
    n_cnt     = cnt;
    n_idx     = idx;
    n_snap    = snap;
    n_rs      = rs_q;
    n_data    = data_q;
    n_e       = e_q;
    n_busy    = busy_q;
    n_ready   = ready_q;
    n_fd      = 1'b0;
    load_byte = 1'b0;
    ci        = '0;

    case (state)
      POWERON: begin
        if (cnt == PON_LAST) begin
          n_state   = INIT;
          n_phase   = SETUP;
          n_idx     = '0;
          load_byte = 1'b1;
        end else begin
          n_cnt = cnt + 1'b1;
        end
      end
      INIT, FRAME: begin
        case (phase)
          SETUP: begin
            n_phase = PULSE;
            n_cnt   = EP_LAST;
            n_e     = 1'b1;
          end
          PULSE: begin
            if (cnt == '0) begin
              n_phase = HOLD;
              n_e     = 1'b0;
              n_cnt   = (state == INIT && idx == 6'd3) ? CLR_LAST : CMD_LAST;
            end else begin
              n_cnt = cnt - 1'b1;
            end
          end
          default: begin
            if (cnt != '0) begin
              n_cnt = cnt - 1'b1;
            end else if (state == INIT && idx == 6'd3) begin
              n_ready   = 1'b1;
              n_snap    = characters;
              n_state   = FRAME;
              n_idx     = '0;
              n_phase   = SETUP;
              load_byte = 1'b1;
            end else if (state == FRAME && idx == 6'd33) begin
              n_state = IDLE;
              n_busy  = 1'b0;
              n_fd    = 1'b1;
            end else begin
              n_idx     = idx + 1'b1;
              n_phase   = SETUP;
              load_byte = 1'b1;
            end
          end
        endcase
      end
      default: begin
        if (characters != snap) begin
          n_snap    = characters;
          n_state   = FRAME;
          n_idx     = '0;
          n_phase   = SETUP;
          n_busy    = 1'b1;
          load_byte = 1'b1;
        end
      end
    endcase

    // Byte registers load on entry to setup; frame data bytes (idx >= 1) read the
    // already-registered snapshot, which only changes alongside idx 0.
    if (load_byte) begin
      if (n_state == INIT) begin
        n_rs = 1'b0;
        case (n_idx)
          6'd0:    n_data = 8'h38;
          6'd1:    n_data = 8'h0C;
          6'd2:    n_data = 8'h06;
          default: n_data = 8'h01;
        endcase
      end else if (n_idx == 6'd0) begin
        n_rs   = 1'b0;
        n_data = 8'h80;
      end else if (n_idx == 6'd17) begin
        n_rs   = 1'b0;
        n_data = 8'hC0;
      end else begin
        n_rs   = 1'b1;
        ci     = (n_idx <= 6'd16) ? 5'(n_idx - 6'd1) : 5'(n_idx - 6'd2);
        n_data = snap[{ci, 3'b000} +: 8];
      end
    end
  end

  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_E      = e_q;
  assign LCD_DATA   = data_q;
  assign busy       = busy_q;
  assign ready      = ready_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Scoreboard bench for lcd_text_writer: expected LCD bytes are queued as stimulus
// is issued; a monitor pops one entry per LCD_E rising edge and checks it.
module tb_lcd_text_writer;

  localparam int unsigned PW  = 10;
  localparam int unsigned EP  = 2;
  localparam int unsigned CW  = 3;
  localparam int unsigned CLW = 8;

  logic         CLK = 1'b0;
  logic         Reset;
  logic [255:0] characters;
  logic         LCD_RS, LCD_RW, LCD_E, busy, ready, frame_done;
  logic [7:0]   LCD_DATA;

  lcd_text_writer #(
    .POWERON_WAIT(PW), .E_PULSE(EP), .CMD_WAIT(CW), .CLEAR_WAIT(CLW), .CNT_W(20)
  ) dut (
    .CLK(CLK), .Reset(Reset), .characters(characters),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_DATA(LCD_DATA),
    .busy(busy), .ready(ready), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rs;
    logic [7:0]  d;
    int unsigned gap;   // cycles since previous E rise (or reset release); 0 = unchecked
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   failed = 0;
  int   bytes_seen = 0;
  int   fd_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [255:0] make_img(input string l1, input string l2);
    logic [255:0] img;
    img = '0;
    for (int i = 0; i < 16; i++) begin
      img[8*i +: 8]      = (i < l1.len()) ? l1[i] : 8'h20;
      img[8*(16+i) +: 8] = (i < l2.len()) ? l2[i] : 8'h20;
    end
    return img;
  endfunction

  function automatic logic [255:0] rand_img();
    logic [255:0] img;
    for (int i = 0; i < 32; i++) img[8*i +: 8] = 8'($urandom_range(32, 126));
    return img;
  endfunction

  task automatic push(input logic rs, input logic [7:0] d, input int unsigned gap, input logic rdy);
    exp_t e;
    e.rs = rs; e.d = d; e.gap = gap; e.rdy = rdy;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push(1'b0, 8'h38, PW + 1, 1'b0);
    push(1'b0, 8'h0C, EP + CW + 1, 1'b0);
    push(1'b0, 8'h06, EP + CW + 1, 1'b0);
    push(1'b0, 8'h01, EP + CW + 1, 1'b0);
  endtask

  // A frame is the line-1 address, 16 chars, the line-2 address, 16 chars.
  task automatic push_frame(input logic [255:0] img, input int unsigned first_gap);
    push(1'b0, 8'h80, first_gap, 1'b1);
    for (int i = 0; i < 16; i++) push(1'b1, img[8*i +: 8], EP + CW + 1, 1'b1);
    push(1'b0, 8'hC0, EP + CW + 1, 1'b1);
    for (int i = 16; i < 32; i++) push(1'b1, img[8*i +: 8], EP + CW + 1, 1'b1);
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n = 0;
    while (fd_count < target && n < budget) begin
      tick();
      n++;
    end
    check("frame_done count", 32'(fd_count), 32'(target));
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n = 0;
    while (bytes_seen < target && n < budget) begin
      tick();
      n++;
    end
    check("byte count reached", 32'(bytes_seen), 32'(target));
  endtask

  // Monitor: samples on the falling edge, scoring each byte against the queue.
  initial begin
    logic        e_prev = 1'b0;
    logic        fd_prev = 1'b0;
    int unsigned since = 0;
    int unsigned hi = 0;
    logic [8:0]  at_rise = '0;
    exp_t        x;
    forever begin
      @(negedge CLK);
      if (Reset === 1'b1) begin
        since = 0; hi = 0; e_prev = 1'b0; fd_prev = 1'b0;
      end else begin
        since++;
        if (LCD_E === 1'b1 && !e_prev) begin
          bytes_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected byte", {23'd0, LCD_RS, LCD_DATA}, 32'hFFFF_FFFF);
          end else begin
            x = exp_q.pop_front();
            check("byte rs/data", {23'd0, LCD_RS, LCD_DATA}, {23'd0, x.rs, x.d});
            check("byte ready", 32'(ready), 32'(x.rdy));
            check("byte busy", 32'(busy), 32'd1);
            check("byte rw", 32'(LCD_RW), 32'd0);
            if (x.gap != 0) check("byte spacing", since, x.gap);
          end
          since = 0;
          hi = 1;
          at_rise = {LCD_RS, LCD_DATA};
        end else if (LCD_E === 1'b1) begin
          hi++;
        end else if (e_prev) begin
          check("E high width", hi, EP);
          check("rs/data held through E", 32'({LCD_RS, LCD_DATA}), 32'(at_rise));
        end
        if (frame_done === 1'b1) begin
          fd_count++;
          check("busy low at frame_done", 32'(busy), 32'd0);
          check("frame_done single pulse", 32'(fd_prev), 32'd0);
        end
        e_prev  = (LCD_E === 1'b1);
        fd_prev = (frame_done === 1'b1);
      end
    end
  end

  initial begin
    logic [255:0] img_a, img_b;
    int base;
    int fds;

    Reset = 1'b1;
    characters = make_img("Cave of", "Wonders");
    repeat (3) tick();
    check("reset E", 32'(LCD_E), 32'd0);
    check("reset RS", 32'(LCD_RS), 32'd0);
    check("reset RW", 32'(LCD_RW), 32'd0);
    check("reset DATA", 32'(LCD_DATA), 32'd0);
    check("reset busy", 32'(busy), 32'd1);
    check("reset ready", 32'(ready), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);

    push_init();
    push_frame(characters, EP + CLW + 1);
    Reset = 1'b0;
    wait_fd(1, 2000);
    check("frame 1 drained", 32'(exp_q.size()), 32'd0);
    check("ready after init", 32'(ready), 32'd1);
    check("busy after frame 1", 32'(busy), 32'd0);

    base = bytes_seen;
    repeat (500) tick();
    check("idle no bytes", 32'(bytes_seen - base), 32'd0);
    check("idle busy", 32'(busy), 32'd0);
    check("idle no frame_done", 32'(fd_count), 32'd1);

    characters = make_img("Twisty Tunnel", "Exits: N S");
    push_frame(characters, 0);
    tick();
    check("busy rises on change", 32'(busy), 32'd1);
    wait_fd(2, 1000);
    repeat (50) tick();
    check("twisty one frame", 32'(fd_count), 32'd2);
    check("twisty drained", 32'(exp_q.size()), 32'd0);

    img_a = rand_img();
    img_b = rand_img();
    characters = img_a;
    push_frame(img_a, 0);
    base = bytes_seen;
    wait_bytes(base + 10, 500);
    characters = img_b;
    push_frame(img_b, 0);
    wait_fd(4, 2000);
    repeat (100) tick();
    check("midframe exactly two frames", 32'(fd_count), 32'd4);
    check("midframe drained", 32'(exp_q.size()), 32'd0);
    check("midframe idle busy", 32'(busy), 32'd0);

    for (int k = 0; k < 3; k++) begin
      characters = rand_img();
      push_frame(characters, 0);
      wait_fd(5 + k, 1000);
    end
    check("random frames drained", 32'(exp_q.size()), 32'd0);

    characters = rand_img();
    push_frame(characters, 0);
    base = bytes_seen;
    wait_bytes(base + 21, 1000);
    check("E high before reset", 32'(LCD_E), 32'd1);
    Reset = 1'b1;
    exp_q.delete();
    tick();
    check("reset mid-byte E", 32'(LCD_E), 32'd0);
    check("reset mid-byte ready", 32'(ready), 32'd0);
    check("reset mid-byte busy", 32'(busy), 32'd1);
    tick();
    fds = fd_count;
    push_init();
    push_frame(characters, EP + CLW + 1);
    Reset = 1'b0;
    wait_fd(fds + 1, 2000);
    check("re-init drained", 32'(exp_q.size()), 32'd0);
    check("re-init ready", 32'(ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
